// File: rtl/kronos_wb_pkg.sv
// kronos_wb_pkg: execute-to-writeback pipeline types for the Kronos RV32I write-back stage
//   pipeEXWB_t : EX results plus control fields consumed by kronos_wb
//   LD_*       : ld_size encodings (2'b11 behaves as word)
//   wb_state_e : write-back FSM states
package kronos_wb_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    typedef enum logic {WB_IDLE, WB_MEM} wb_state_e;

    typedef struct packed {
        logic [31:0] result1;
        logic [31:0] result2;
        logic [4:0]  rd;
        logic        rd_write;
        logic        branch;
        logic        branch_cond;
        logic        ld;
        logic        st;
        logic [1:0]  ld_size;
        logic        ld_sign;
        logic        illegal;
    } pipeEXWB_t;

endpackage

// File: rtl/kronos_lsu_align.sv
// kronos_lsu_align: byte-lane alignment for loads and stores
//   offset, size, sign : byte offset in word, access size, load sign-extension
//   st_data -> wr_data : store data shifted onto its byte lanes, mask = byte enables
//   rd_data -> ld_data : read word shifted down, truncated and extended
module kronos_lsu_align
    import kronos_wb_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  mask,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);
    logic [31:0] sh;

    assign mask    = size == LD_BYTE ? 4'b0001 << offset : size == LD_HALF ? 4'b0011 << offset : 4'hF;
    assign wr_data = st_data << {offset, 3'b000};
    assign sh      = rd_data >> {offset, 3'b000};
    assign ld_data = size == LD_BYTE ? {{24{sign & sh[7]}}, sh[7:0]}
                   : size == LD_HALF ? {{16{sign & sh[15]}}, sh[15:0]} : sh;

endmodule

// File: rtl/kronos_wb.sv
// kronos_wb: Kronos RV32I write-back stage (register commit, branch redirect, traps, data bus)
//   execute/execute_vld/execute_rdy : EX->WB handshake carrying pipeEXWB_t
//   regwr_*                         : register-file write, one-cycle strobe
//   branch/branch_target            : PC redirect, one-cycle strobe
//   trap                            : illegal instruction or misaligned access, one-cycle strobe
//   data_*                          : request/acknowledge data bus
//   KRONOS_WB_MISALIGN_TRAP_EN      : when defined, misaligned half/word accesses trap instead
//                                     of being forced aligned
module kronos_wb
    import kronos_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  pipeEXWB_t   execute,
    input  logic        execute_vld,
    output logic        execute_rdy,
    output logic [31:0] regwr_data,
    output logic [4:0]  regwr_sel,
    output logic        regwr_en,
    output logic [31:0] branch_target,
    output logic        branch,
    output logic        trap,
    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack
);
    wb_state_e   state;
    logic [1:0]  a;
    logic [1:0]  a_eff;
    logic [1:0]  a_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [4:0]  rd_q;
    logic        mem_op;
    logic        misalign;
    logic        accept;
    logic        idle;
    logic [3:0]  mask;
    logic [31:0] st_shift;
    logic [31:0] ld_data;

    assign idle        = state == WB_IDLE;
    assign execute_rdy = idle && !rst;
    assign data_req    = state == WB_MEM;
    assign accept      = execute_vld && execute_rdy;
    assign a           = execute.result1[1:0];
    assign mem_op      = execute.ld || execute.st;
    // Halves keep only the half-word select bit; words (and size 11) are always lane 0.
    assign a_eff       = execute.ld_size == LD_BYTE ? a : execute.ld_size == LD_HALF ? (a & 2'b10) : 2'b00;

`ifdef KRONOS_WB_MISALIGN_TRAP_EN
    assign misalign = mem_op && a_eff != a;
`else
    assign misalign = 1'b0;
`endif

    // Store alignment uses the incoming instruction; load alignment uses the latched access.
    kronos_lsu_align u_align (
        .offset  (idle ? a_eff : a_q),
        .size    (idle ? execute.ld_size : size_q),
        .sign    (sign_q),
        .st_data (execute.result2),
        .rd_data (data_rd_data),
        .mask    (mask),
        .wr_data (st_shift),
        .ld_data (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WB_IDLE;
            regwr_data    <= '0;
            regwr_sel     <= '0;
            regwr_en      <= 1'b0;
            branch_target <= '0;
            branch        <= 1'b0;
            trap          <= 1'b0;
            data_addr     <= '0;
            data_wr_data  <= '0;
            data_mask     <= '0;
            data_wr_en    <= 1'b0;
            a_q           <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
            rd_q          <= '0;
        end else begin
            regwr_en <= 1'b0;
            branch   <= 1'b0;
            trap     <= 1'b0;
            if (accept) begin
                if (execute.illegal || misalign) begin
                    trap <= 1'b1;
                end else if (mem_op) begin
                    state        <= WB_MEM;
                    data_addr    <= {execute.result1[31:2], 2'b00};
                    data_mask    <= mask;
                    data_wr_data <= execute.st ? st_shift : '0;
                    data_wr_en   <= execute.st;
                    a_q          <= a_eff;
                    size_q       <= execute.ld_size;
                    sign_q       <= execute.ld_sign;
                    rd_q         <= execute.rd;
                end else begin
                    regwr_en      <= execute.rd_write && execute.rd != 5'd0;
                    regwr_sel     <= execute.rd;
                    regwr_data    <= execute.result1;
                    branch        <= execute.branch || (execute.branch_cond && execute.result1[0]);
                    branch_target <= execute.result2;
                end
            end else if (state == WB_MEM && data_ack) begin
                state <= WB_IDLE;
                if (!data_wr_en) begin
                    regwr_en   <= rd_q != 5'd0;
                    regwr_sel  <= rd_q;
                    regwr_data <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_kronos_wb.sv
// tb_kronos_wb: directed self-checking bench for kronos_wb
module tb_kronos_wb;
    import kronos_wb_pkg::*;

    logic        clk;
    logic        rst;
    pipeEXWB_t   execute;
    logic        execute_vld;
    logic        execute_rdy;
    logic [31:0] regwr_data;
    logic [4:0]  regwr_sel;
    logic        regwr_en;
    logic [31:0] branch_target;
    logic        branch;
    logic        trap;
    logic [31:0] data_addr;
    logic [31:0] data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en;
    logic        data_req;
    logic [31:0] data_rd_data;
    logic        data_ack;

    int tests = 0;
    int fails = 0;

    kronos_wb dut (
        .clk           (clk),
        .rst           (rst),
        .execute       (execute),
        .execute_vld   (execute_vld),
        .execute_rdy   (execute_rdy),
        .regwr_data    (regwr_data),
        .regwr_sel     (regwr_sel),
        .regwr_en      (regwr_en),
        .branch_target (branch_target),
        .branch        (branch),
        .trap          (trap),
        .data_addr     (data_addr),
        .data_wr_data  (data_wr_data),
        .data_mask     (data_mask),
        .data_wr_en    (data_wr_en),
        .data_req      (data_req),
        .data_rd_data  (data_rd_data),
        .data_ack      (data_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b1;
        execute      = '0;
        execute_vld  = 1'b0;
        data_rd_data = '0;
        data_ack     = 1'b0;
        step();
        step();
        chk("rst_rdy", {31'd0, execute_rdy}, 0);
        chk("rst_req", {31'd0, data_req}, 0);
        chk("rst_regwr", {31'd0, regwr_en}, 0);
        chk("rst_trap", {31'd0, trap}, 0);
        chk("rst_mask", {28'd0, data_mask}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", {31'd0, execute_rdy}, 1);

        // ALU op rd=5
        execute = '0; execute.rd = 5; execute.rd_write = 1; execute.result1 = 32'h1234_5678;
        execute_vld = 1;
        step();
        execute_vld = 0;
        chk("alu_en", {31'd0, regwr_en}, 1);
        chk("alu_sel", {27'd0, regwr_sel}, 5);
        chk("alu_data", regwr_data, 32'h1234_5678);
        step();
        chk("alu_en_pulse", {31'd0, regwr_en}, 0);

        // ALU op rd=0
        execute.rd = 0; execute_vld = 1;
        step();
        execute_vld = 0;
        chk("alu_x0_en", {31'd0, regwr_en}, 0);

        // JAL rd=1
        execute = '0; execute.rd = 1; execute.rd_write = 1; execute.branch = 1;
        execute.result1 = 32'h104; execute.result2 = 32'h400; execute_vld = 1;
        step();
        execute_vld = 0;
        chk("jal_en", {31'd0, regwr_en}, 1);
        chk("jal_data", regwr_data, 32'h104);
        chk("jal_branch", {31'd0, branch}, 1);
        chk("jal_target", branch_target, 32'h400);
        step();
        chk("jal_branch_pulse", {31'd0, branch}, 0);

        // Conditional branch, not taken then taken
        execute = '0; execute.branch_cond = 1; execute.result1 = 32'h100; execute.result2 = 32'h800; execute_vld = 1;
        step();
        chk("bcond_nt", {31'd0, branch}, 0);
        execute.result1 = 32'h1;
        step();
        execute_vld = 0;
        chk("bcond_t", {31'd0, branch}, 1);
        chk("bcond_target", branch_target, 32'h800);

        // Back-to-back ALU ops
        execute = '0; execute.rd_write = 1; execute.rd = 3; execute.result1 = 32'hAAAA_0001; execute_vld = 1;
        step();
        chk("b2b_a", regwr_data, 32'hAAAA_0001);
        execute.rd = 4; execute.result1 = 32'hBBBB_0002;
        step();
        execute_vld = 0;
        chk("b2b_b", regwr_data, 32'hBBBB_0002);
        chk("b2b_b_sel", {27'd0, regwr_sel}, 4);
        chk("b2b_b_en", {31'd0, regwr_en}, 1);

        // Signed byte load at 0x1003, ack after 3 cycles
        execute = '0; execute.ld = 1; execute.ld_size = LD_BYTE; execute.ld_sign = 1;
        execute.rd = 7; execute.rd_write = 1; execute.result1 = 32'h1003; execute_vld = 1;
        step();
        execute = '0; execute.illegal = 1;
        chk("lb_req", {31'd0, data_req}, 1);
        chk("lb_addr", data_addr, 32'h1000);
        chk("lb_mask", {28'd0, data_mask}, 4'b1000);
        chk("lb_wr_en", {31'd0, data_wr_en}, 0);
        chk("lb_rdy", {31'd0, execute_rdy}, 0);
        data_rd_data = 32'h8012_3456;
        step();
        chk("lb_busy_trap", {31'd0, trap}, 0);
        chk("lb_hold_addr", data_addr, 32'h1000);
        step();
        execute_vld = 0;
        chk("lb_hold_req", {31'd0, data_req}, 1);
        chk("lb_hold_rdy", {31'd0, execute_rdy}, 0);
        data_ack = 1;
        step();
        data_ack = 0;
        chk("lb_en", {31'd0, regwr_en}, 1);
        chk("lb_sel", {27'd0, regwr_sel}, 7);
        chk("lb_data", regwr_data, 32'hFFFF_FF80);
        chk("lb_done_req", {31'd0, data_req}, 0);
        chk("lb_done_rdy", {31'd0, execute_rdy}, 1);
        chk("lb_no_trap", {31'd0, trap}, 0);
        step();
        chk("lb_en_pulse", {31'd0, regwr_en}, 0);

        // Unsigned half load at 0x12, same-cycle ack
        execute = '0; execute.ld = 1; execute.ld_size = LD_HALF; execute.rd = 8; execute.rd_write = 1;
        execute.result1 = 32'h12; execute_vld = 1;
        step();
        execute_vld = 0;
        data_rd_data = 32'h8001_7777; data_ack = 1;
        chk("lhu_mask", {28'd0, data_mask}, 4'b1100);
        step();
        data_ack = 0;
        chk("lhu_data", regwr_data, 32'h0000_8001);

        // Half store at 0x2002, ack with req, next op queued
        execute = '0; execute.st = 1; execute.ld_size = LD_HALF; execute.rd = 9;
        execute.result1 = 32'h2002; execute.result2 = 32'h0000_BEEF; execute_vld = 1;
        step();
        execute = '0; execute.rd = 9; execute.rd_write = 1; execute.result1 = 32'h55;
        data_ack = 1;
        chk("sh_req", {31'd0, data_req}, 1);
        chk("sh_wdata", data_wr_data, 32'hBEEF_0000);
        chk("sh_mask", {28'd0, data_mask}, 4'b1100);
        chk("sh_wr_en", {31'd0, data_wr_en}, 1);
        chk("sh_addr", data_addr, 32'h2000);
        chk("sh_rdy", {31'd0, execute_rdy}, 0);
        step();
        data_ack = 0;
        chk("sh_no_regwr", {31'd0, regwr_en}, 0);
        chk("sh_done_req", {31'd0, data_req}, 0);
        chk("sh_done_rdy", {31'd0, execute_rdy}, 1);
        step();
        execute_vld = 0;
        chk("sh_next_en", {31'd0, regwr_en}, 1);
        chk("sh_next_data", regwr_data, 32'h55);

        // Illegal instruction
        execute = '0; execute.illegal = 1; execute.rd = 2; execute.rd_write = 1; execute.branch = 1; execute.ld = 1;
        execute_vld = 1;
        step();
        execute_vld = 0;
        chk("ill_trap", {31'd0, trap}, 1);
        chk("ill_regwr", {31'd0, regwr_en}, 0);
        chk("ill_branch", {31'd0, branch}, 0);
        chk("ill_req", {31'd0, data_req}, 0);
        step();
        chk("ill_trap_pulse", {31'd0, trap}, 0);
        chk("ill_req2", {31'd0, data_req}, 0);

        // Misaligned word load at 0x3001
        execute = '0; execute.ld = 1; execute.ld_size = LD_WORD; execute.rd = 6; execute.rd_write = 1;
        execute.result1 = 32'h3001; execute_vld = 1;
        step();
        execute_vld = 0;
`ifdef KRONOS_WB_MISALIGN_TRAP_EN
        chk("mis_trap", {31'd0, trap}, 1);
        chk("mis_req", {31'd0, data_req}, 0);
        chk("mis_regwr", {31'd0, regwr_en}, 0);
        step();
        chk("mis_trap_pulse", {31'd0, trap}, 0);
        chk("mis_req2", {31'd0, data_req}, 0);
`else
        chk("mis_trap", {31'd0, trap}, 0);
        chk("mis_req", {31'd0, data_req}, 1);
        chk("mis_addr", data_addr, 32'h3000);
        chk("mis_mask", {28'd0, data_mask}, 4'hF);
        data_rd_data = 32'hCAFE_F00D; data_ack = 1;
        step();
        data_ack = 0;
        chk("mis_data", regwr_data, 32'hCAFE_F00D);
        chk("mis_en", {31'd0, regwr_en}, 1);
`endif

        // Reset in the middle of an access
        execute = '0; execute.ld = 1; execute.ld_size = LD_WORD; execute.rd = 10; execute.rd_write = 1;
        execute.result1 = 32'h40; execute_vld = 1;
        step();
        execute_vld = 0;
        chk("rstmid_req_before", {31'd0, data_req}, 1);
        #2;
        rst = 1;
        #1;
        chk("rstmid_req_async", {31'd0, data_req}, 0);
        step();
        rst = 0;
        #1;
        chk("rstmid_rdy", {31'd0, execute_rdy}, 1);
        data_ack = 1; data_rd_data = 32'h1111_2222;
        step();
        data_ack = 0;
        chk("rstmid_no_regwr", {31'd0, regwr_en}, 0);
        chk("rstmid_req_idle", {31'd0, data_req}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
